// File: rtl/dm_arbiter.sv
// ============================================================================
// Module   : dm_arbiter
// Brief    : Two-port (CPU / DMA) arbiter and sequencer for the data memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rstn,
  // CPU port
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic [2:0]  c_ctrl,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic        c_err,
  output logic [31:0] c_rdata,
  // DMA / debug port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_ctrl,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic        d_err,
  output logic [31:0] d_rdata,
  // Memory side
  output logic        DMWr,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_din,
  output logic [2:0]  dm_ctrl,
  input  logic [31:0] dm_dout
);

  localparam logic [2:0] DM_WORD  = 3'd0;
  localparam logic [2:0] DM_HALF  = 3'd1;
  localparam logic [2:0] DM_HALFU = 3'd2;
  localparam logic [2:0] DM_BYTE  = 3'd3;
  localparam logic [2:0] DM_BYTEU = 3'd4;
  localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);

  logic [3:0]  starve_cnt;
  logic        dma_turn;
  logic        any_gnt;
  logic        legal;
  logic        mem_go;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [2:0]  sel_ctrl;

  function automatic logic is_legal(input logic [31:0] addr, input logic [2:0] ctrl);
    logic ok;
    ok = 1'b0;
    case (ctrl)
      DM_WORD:            ok = (addr[1:0] == 2'b00);
      DM_HALF, DM_HALFU:  ok = (addr[0] == 1'b0);
      DM_BYTE, DM_BYTEU:  ok = 1'b1;
      default:            ok = 1'b0;
    endcase
    return ok && (addr[31:9] == 23'd0);
  endfunction

  // CPU has priority unless DMA has been starved for STARVE_LIMIT cycles.
  assign dma_turn = (starve_cnt == LIMIT);
  assign c_gnt    = c_req & (~d_req | ~dma_turn);
  assign d_gnt    = d_req & ~c_gnt;
  assign any_gnt  = c_gnt | d_gnt;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = 32'd0;
    sel_wdata = 32'd0;
    sel_ctrl  = 3'd0;
    if (c_gnt) begin
      sel_we    = c_we;
      sel_addr  = c_addr;
      sel_wdata = c_wdata;
      sel_ctrl  = c_ctrl;
    end else if (d_gnt) begin
      sel_we    = d_we;
      sel_addr  = d_addr;
      sel_wdata = d_wdata;
      sel_ctrl  = d_ctrl;
    end
  end

  assign legal   = is_legal(sel_addr, sel_ctrl);
  assign mem_go  = any_gnt & legal;
  assign DMWr    = mem_go & sel_we;
  assign dm_addr = mem_go ? sel_addr  : 32'd0;
  assign dm_din  = mem_go ? sel_wdata : 32'd0;
  assign dm_ctrl = mem_go ? sel_ctrl  : 3'd0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_cnt <= 4'd0;
    end else if (!d_req || d_gnt) begin
      starve_cnt <= 4'd0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // rdata is only updated on a response so it holds between responses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      c_rvalid <= 1'b0;
      c_err    <= 1'b0;
      c_rdata  <= 32'd0;
      d_rvalid <= 1'b0;
      d_err    <= 1'b0;
      d_rdata  <= 32'd0;
    end else begin
      c_rvalid <= c_gnt;
      c_err    <= c_gnt & ~legal;
      d_rvalid <= d_gnt;
      d_err    <= d_gnt & ~legal;
      if (c_gnt) begin
        c_rdata <= (legal && !c_we) ? dm_dout : 32'd0;
      end
      if (d_gnt) begin
        d_rdata <= (legal && !d_we) ? dm_dout : 32'd0;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter and sequencer in front of the single-ported data memory (`dm`). It shares the memory between the CPU MEM-stage load/store port (port 0) and a DMA/debug port (port 1), using fixed CPU priority with a starvation guard for DMA. It rejects misaligned or illegal accesses before they reach memory, and it returns registered read responses with a per-port valid/error flag.

## Interface
- `STARVE_LIMIT`, 4: consecutive denied DMA cycles after which DMA wins one arbitration. Legal range 1–15.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `c_req` input 1: CPU request valid.
- `c_we` input 1: CPU write (1) or read (0).
- `c_addr` input 32: CPU byte address.
- `c_wdata` input 32: CPU write data.
- `c_ctrl` input 3: CPU access size, `dm_*` encoding from ctrl_encode_def.v.
- `c_gnt` output 1: CPU request accepted this cycle.
- `c_rvalid` output 1: CPU response valid.
- `c_err` output 1: CPU response is an error.
- `c_rdata` output 32: CPU read data.
- `d_req`, `d_we`, `d_addr`, `d_wdata`, `d_ctrl`, `d_gnt`, `d_rvalid`, `d_err`, `d_rdata`: same widths and meanings as the CPU port, for the DMA port.
- `DMWr` output 1: memory write enable.
- `dm_addr` output 32: memory address.
- `dm_din` output 32: memory write data.
- `dm_ctrl` output 3: memory size control.
- `dm_dout` input 32: memory read data. Combinational from `dm_addr` and `dm_ctrl`.

## Operation
- Requesters hold req, we, addr, wdata and ctrl stable until they see gnt high at a rising edge. A requester may drop req at any time before it is granted.
- Arbitration is combinational, at most one grant per cycle:
  - Only one port requests: that port wins.
  - Both ports request: CPU wins unless `starve_cnt == STARVE_LIMIT`, in which case DMA wins.
- `starve_cnt` (4 bit, saturating at STARVE_LIMIT):
  - Increments on a cycle with `d_req & !d_gnt`.
  - Clears on `d_gnt` or `!d_req`.
- Legality check on the winning request:
  - `dm_word` is illegal if `addr[1:0] != 0`.
  - `dm_halfword` / `dm_halfword_unsigned` are illegal if `addr[0] != 0`.
  - Byte accesses are always aligned.
  - Any ctrl code outside the five `dm_*` codes is illegal.
  - An address with `addr[31:9] != 0` is illegal (outside the 128-word memory).
- Legal winner: `dm_addr`, `dm_din` and `dm_ctrl` come from the winner, and `DMWr = we`.
- Illegal winner: the request is still granted, `DMWr = 0`, and it is answered with an error response.
- No grant: `DMWr = 0`, and `dm_addr`, `dm_din`, `dm_ctrl` are driven to 0.
- Responses are registered and arrive one cycle after the grant:
  - `rvalid` pulses high for exactly one cycle, for reads and writes alike.
  - Legal read: `rdata` holds the `dm_dout` value sampled at the grant edge.
  - Write: `rdata = 0`.
  - Illegal access: `err = 1` and `rdata = 0`.
- `rdata` holds its value until the next response on that port.

## Timing
- Reset values (asynchronous, while `rstn = 0`): all rvalid, err and rdata are 0, and `starve_cnt = 0`.
- Grant latency: gnt is asserted in the same cycle as req when the port wins.
- Write commit: the memory write takes effect at the grant edge.
- Response latency: 1 cycle, so rvalid is high in cycle N+1 for a grant in cycle N.
- Throughput: one access per cycle total. Back-to-back grants to the same port give back-to-back rvalid pulses.
- Read-after-write: a read granted in the cycle after a write to the same word returns the new data.
- Reset asserted mid-operation: a pending response is dropped and no rvalid is issued for it. After `rstn` deasserts, arbitration starts fresh with `starve_cnt = 0`.
- A request dropped before grant produces no response and no memory access.

## Test plan
- CPU alone:
  - Stimulus: write word 0xDEADBEEF to 0x10, then a `dm_byte` read of 0x13.
  - Required: grant each cycle, `DMWr` high for one cycle only; read response arrives one cycle later with `c_rdata = 0xFFFFFFDE`, `c_err = 0`.
- Contention with `STARVE_LIMIT = 4`:
  - Stimulus: `c_req` and `d_req` held high continuously.
  - Required: CPU granted 4 cycles, DMA granted on the 5th, pattern repeats; `d_rvalid` high exactly one cycle after each `d_gnt`.
- Misaligned and out-of-range accesses:
  - Stimulus: `dm_word` write to 0x22 from DMA, and a `dm_halfword` read of 0x201.
  - Required: both granted, `DMWr = 0`, `d_err = 1` and `rdata = 0` on the next cycle, memory contents unchanged.
- Halfword path:
  - Stimulus: DMA writes `dm_halfword` 0x8001 to 0x42; CPU then reads `dm_halfword` and `dm_halfword_unsigned` at 0x42.
  - Required: read data 0xFFFF8001 and 0x00008001 respectively.
- Reset mid-operation:
  - Stimulus: `rstn` pulled low asynchronously between a read grant and its response edge.
  - Required: rvalid, err and rdata go to 0 immediately, no response is issued, and `starve_cnt = 0` after release.
- DMA drops req while being starved:
  - Stimulus: DMA denied 3 cycles, drops `d_req` for 1 cycle, then requests again with CPU still requesting.
  - Required: the counter restarts from 0, so DMA is granted only after 4 further denied cycles.
